mux_n_to_1_stream: RTL and testbench

Parametrised, registered N-channel stream multiplexer, W bits wide. It succeeds the gate-level 4-to-1 selector used in the datapath labs. It adds per-channel valid/ready handshakes, a one-cycle output register, and two selection modes: fixed select, or round-robin over channels with valid data. It sits between several producer streams and one consumer, and it never drops or duplicates a beat.

---
 rtl/mux_n_to_1_stream.sv | 107 ++++++++++
 tb/tb_mux_n_to_1_stream.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_stream.sv
// Registered N-channel stream multiplexer with fixed-select or round-robin arbitration.
// Optional packet lock (hold grant until in_last) is enabled by defining MUX_PKT_LOCK_EN.
module mux_n_to_1_stream #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  logic          load;
  logic          granted;
  logic          accept;
  logic [SW-1:0] g;
  logic [SW-1:0] rr_g;
  logic          rr_found;
  logic [SW-1:0] ptr;

`ifdef MUX_PKT_LOCK_EN
  logic          locked;
  logic [SW-1:0] lchan;
`endif

  // Scan from the channel after the last winner so every valid channel gets a turn.
  always_comb begin
    rr_found = 1'b0;
    rr_g     = '0;
    for (int k = 1; k <= N; k++) begin
      if (!rr_found && in_valid[(int'(ptr) + k) % N]) begin
        rr_found = 1'b1;
        rr_g     = SW'((int'(ptr) + k) % N);
      end
    end
  end

  always_comb begin
    granted = 1'b0;
    g       = '0;
    if (mode) begin
      granted = rr_found;
      g       = rr_g;
    end else begin
      granted = (int'(sel) < N);
      g       = sel;
    end
`ifdef MUX_PKT_LOCK_EN
    if (locked) begin
      granted = 1'b1;
      g       = lchan;
    end
`endif
  end

  assign load   = ~out_valid | out_ready;
  assign accept = load & granted & in_valid[g] & ~reset;

  always_comb begin
    in_ready = '0;
    if (load && granted && !reset) begin
      in_ready[g] = 1'b1;
    end
  end

  // Output register: a new beat may replace a draining one in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
      ptr       <= SW'(N - 1);
`ifdef MUX_PKT_LOCK_EN
      locked    <= 1'b0;
      lchan     <= '0;
`endif
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(g)*W +: W];
      out_last  <= in_last[g];
      out_chan  <= g;
      ptr       <= g;
`ifdef MUX_PKT_LOCK_EN
      if (!in_last[g]) begin
        locked <= 1'b1;
        lchan  <= g;
      end else begin
        locked <= 1'b0;
      end
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// Self-checking bench for mux_n_to_1_stream: directed scenarios plus randomized traffic
// against a cycle-level behavioural model; honours MUX_PKT_LOCK_EN when defined.
module tb_mux_n_to_1_stream;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        mode;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic        reset3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_last3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic        mode3;
  logic [7:0]  out_data3;
  logic        out_last3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit         m_valid;
  bit         m_last;
  logic [7:0] m_data;
  int         m_chan;
  int         m_ptr;
`ifdef MUX_PKT_LOCK_EN
  bit         m_locked;
  int         m_lchan;
`endif
  logic [3:0] exp_ready;
  logic [3:0] obs_ready;

  mux_n_to_1_stream #(.N(4), .W(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .sel(sel), .mode(mode),
    .out_data(out_data), .out_last(out_last), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_n_to_1_stream #(.N(3), .W(8)) dut3 (
    .clk(clk), .reset(reset3), .in_data(in_data3), .in_valid(in_valid3),
    .in_last(in_last3), .in_ready(in_ready3), .sel(sel3), .mode(mode3),
    .out_data(out_data3), .out_last(out_last3), .out_chan(out_chan3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Which channel the rules say wins this cycle, or -1 for none.
  function automatic int model_grant();
`ifdef MUX_PKT_LOCK_EN
    if (m_locked) return m_lchan;
`endif
    if (!mode) return int'(sel);
    for (int k = 1; k <= 4; k++) begin
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  // Let inputs settle, record in_ready and its expected value, advance the model, cross one edge.
  task automatic tick();
    int g;
    bit ld;
    #1;
    obs_ready = in_ready;
    g  = model_grant();
    ld = !m_valid || out_ready;
    exp_ready = (g >= 0 && ld && !reset) ? 4'(1 << g) : 4'b0000;
    if (reset) begin
      m_valid = 0; m_data = 8'h00; m_last = 0; m_chan = 0; m_ptr = 3;
`ifdef MUX_PKT_LOCK_EN
      m_locked = 0; m_lchan = 0;
`endif
    end else if (g >= 0 && ld && in_valid[g]) begin
      m_valid = 1;
      m_data  = in_data[g*8 +: 8];
      m_last  = in_last[g];
      m_chan  = g;
      m_ptr   = g;
`ifdef MUX_PKT_LOCK_EN
      if (!in_last[g]) begin
        m_locked = 1; m_lchan = g;
      end else begin
        m_locked = 0;
      end
`endif
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    in_data   = $urandom;
    out_ready = 1'b1;
    mode      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_ready !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_in_ready cyc%0d: got %b expected 0000", i, obs_ready);
      end
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_outputs cyc%0d: got valid=%b data=%h expected 0/00", i, out_valid, out_data);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (obs_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL reset_first_grant: in_ready=%b expected 0001", obs_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_first_beat: valid=%b chan=%0d expected 1/0", out_valid, out_chan);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    mode      = 1'b1;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    in_data   = 32'h43_32_21_10;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] want_data;
      want_data = 8'(8'h10 + 8'h11 * (i % 4));
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_chan !== 2'(i % 4) || out_data !== want_data) begin
        errors++;
        $display("[TB] FAIL rr_fair beat%0d: valid=%b chan=%0d data=%h expected 1/%0d/%h",
                 i, out_valid, out_chan, out_data, i % 4, want_data);
      end
    end
  endtask

  task automatic test_fixed_select();
    do_reset();
    mode      = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'b0100;
    in_last   = 4'b1111;
    in_data   = 32'h00_A5_00_00;
    out_ready = 1'b1;
    tick();
    checks++;
    if (obs_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL fixed_ready: got %b expected 0100", obs_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_chan !== 2'd2) begin
      errors++;
      $display("[TB] FAIL fixed_beat: valid=%b data=%h chan=%0d expected 1/a5/2", out_valid, out_data, out_chan);
    end
    // Three-channel instance with an out-of-range select never grants anything.
    reset3     = 1'b0;
    mode3      = 1'b0;
    sel3       = 2'd3;
    in_valid3  = 3'b111;
    in_last3   = 3'b111;
    in_data3   = 24'hC3_B2_A1;
    out_ready3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready3 !== 3'b000) begin
        errors++;
        $display("[TB] FAIL oor_ready cyc%0d: got %b expected 000", i, in_ready3);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid3 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL oor_valid cyc%0d: got %b expected 0", i, out_valid3);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode      = 1'b1;
    in_last   = 4'b1111;
    in_valid  = 4'b0001;
    in_data   = 32'h00_00_00_5A;
    out_ready = 1'b1;
    tick();
    in_valid  = 4'b0010;
    in_data   = 32'h00_00_3C_00;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h5A) begin
        errors++;
        $display("[TB] FAIL bp_hold cyc%0d: ready=%b valid=%b data=%h expected 0000/1/5a",
                 i, obs_ready, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (obs_ready !== 4'b0010 || out_valid !== 1'b1 || out_data !== 8'h3C || out_chan !== 2'd1) begin
      errors++;
      $display("[TB] FAIL bp_release: ready=%b valid=%b data=%h chan=%0d expected 0010/1/3c/1",
               obs_ready, out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_packet_lock();
    int seq[4];
    int b0;
`ifdef MUX_PKT_LOCK_EN
    seq = '{0, 0, 0, 1};
`else
    seq = '{0, 1, 0, 1};
`endif
    do_reset();
    mode      = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h00_00_B1_A0;
    b0        = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = {2'b00, 1'b1, (b0 < 3)};
      in_last  = {3'b111, (b0 == 2)};
      tick();
      checks++;
      if (obs_ready !== 4'(1 << seq[i]) || out_chan !== 2'(seq[i]) || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL pkt_lock beat%0d: ready=%b chan=%0d valid=%b expected chan %0d",
                 i, obs_ready, out_chan, out_valid, seq[i]);
      end
      if (seq[i] == 0) b0++;
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b0100;
    in_last   = 4'b0000;
    in_data   = 32'h44_33_22_11;
    tick();
    reset    = 1'b1;
    in_valid = 4'b1111;
    tick();
    checks++;
    if (obs_ready !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midpkt_reset: ready=%b valid=%b expected 0000/0", obs_ready, out_valid);
    end
    reset   = 1'b0;
    in_last = 4'b1111;
    tick();
    checks++;
    if (obs_ready !== 4'b0001 || out_chan !== 2'd0 || out_data !== 8'h11) begin
      errors++;
      $display("[TB] FAIL midpkt_restart: ready=%b chan=%0d data=%h expected 0001/0/11",
               obs_ready, out_chan, out_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (obs_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL rand_ready cyc%0d: got %b expected %b", i, obs_ready, exp_ready);
      end
      checks++;
      if (out_valid !== m_valid) begin
        errors++;
        $display("[TB] FAIL rand_valid cyc%0d: got %b expected %b", i, out_valid, m_valid);
      end else if (m_valid && (out_data !== m_data || out_chan !== 2'(m_chan) || out_last !== m_last)) begin
        errors++;
        $display("[TB] FAIL rand_beat cyc%0d: data=%h chan=%0d last=%b expected %h/%0d/%b",
                 i, out_data, out_chan, out_last, m_data, m_chan, m_last);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_valid = '0; in_last = '0;
    sel = '0; mode = 1'b0; out_ready = 1'b1;
    reset3 = 1'b1; in_data3 = '0; in_valid3 = '0; in_last3 = '0;
    sel3 = '0; mode3 = 1'b0; out_ready3 = 1'b1;
    m_valid = 0; m_data = 8'h00; m_last = 0; m_chan = 0; m_ptr = 3;
`ifdef MUX_PKT_LOCK_EN
    m_locked = 0; m_lchan = 0;
`endif
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_fixed_select();
    test_backpressure();
    test_packet_lock();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
